// File: rtl/serial_adder8.sv
// Bit-serial adder: one full-adder stage per clock, LSB first, with the carry held in a flop.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepted edge
// SHIFT | one sum bit per cycle, WIDTH cycles
// DONE  | one-cycle done pulse; sum/carry just updated
module serial_adder8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic             c, c_nxt, sum_bit, last;
  logic [CW-1:0]    cnt;

  assign sum_bit = a_sh[0] ^ b_sh[0] ^ c;
  assign c_nxt   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign sum_nxt = (sum_sh >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Result registers load on the final SHIFT edge so they stay stable through the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      carry  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      a_sh   <= in1;
      b_sh   <= in2;
      c      <= cin;
      cnt    <= '0;
      sum_sh <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_nxt;
      c      <= c_nxt;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum   <= sum_nxt;
        carry <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
        // c is the carry into the MSB stage, c_nxt the carry out of it.
        ovf   <= c ^ c_nxt;
`endif
      end
    end
  end

endmodule
